// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core
// Brief    : Full-duplex UART with TX/RX FIFOs, optional parity, 1-2 stop bits
// Revision : 1.0 - initial release
// ============================================================================

module uart_core_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

module uart_core #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_sig,
  output logic                  tx_sig,
  input  logic [DATA_WIDTH-1:0] data_from_sensor,
  input  logic                  valid_from_sensor,
  output logic                  ready_to_sensor,
  output logic [DATA_WIDTH-1:0] sensor_data,
  output logic                  sensor_valid,
  input  logic                  sensor_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(2 * CPB);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CPB - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);
  localparam logic          PAR_EN    = (PARITY != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // ---------------------------------------------------------------- TX path
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_full, tx_empty, tx_pop, tx_load, tx_alive_q;
  logic [2:0]            tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]         tx_idx_q, tx_idx_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d, tx_q, tx_d;

  uart_core_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push_i(valid_from_sensor && ready_to_sensor),
    .wdata_i(data_from_sensor), .pop_i(tx_pop), .rdata_o(tx_head),
    .full_o(tx_full), .empty_o(tx_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    case (tx_state_q)
      S_START: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      S_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_idx_q == IDX_LAST) begin
          tx_state_d = PAR_EN ? S_PAR : S_STOP;
          tx_d       = PAR_EN ? tx_par_q : 1'b1;
        end else begin
          tx_idx_d   = tx_idx_q + 1'b1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      S_PAR: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = S_STOP;
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
      end
      S_STOP: tx_load = (tx_cnt_q == STOP_LAST);
      default: begin
        tx_cnt_d = '0;
        tx_load  = !tx_empty;
      end
    endcase
    // Both IDLE and end-of-STOP reload here, so back-to-back frames have no gap.
    if (tx_load) begin
      tx_cnt_d = '0;
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_d = S_START;
        tx_shift_d = tx_head;
        tx_par_d   = (^tx_head) ^ PAR_ODD;
        tx_d       = 1'b0;
      end else begin
        tx_state_d = S_IDLE;
        tx_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_alive_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_alive_q <= 1'b1;
    end
  end

  assign tx_sig          = tx_q;
  assign ready_to_sensor = tx_alive_q && !tx_full;

  // ---------------------------------------------------------------- RX path
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  rx_full, rx_empty, rx_pop, rx_push, rx_done;
  logic                  rx_s1_q, rx_s2_q, rx_good, rx_bad_par;
  logic [2:0]            rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]         rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_par_q, rx_par_d;
  logic                  perr_q, ferr_q, ovr_q;

  uart_core_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push_i(rx_push), .wdata_i(rx_shift_q),
    .pop_i(rx_pop), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
        rx_idx_d   = rx_idx_q + 1'b1;
        if (rx_idx_q == IDX_LAST) rx_state_d = PAR_EN ? S_PAR : S_STOP;
      end
      S_PAR: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_par_d   = rx_s2_q;
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_done    = 1'b1;
        rx_state_d = S_IDLE;
      end
      default: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = S_START;
      end
    endcase
  end

  assign rx_bad_par = PAR_EN && (((^rx_shift_q) ^ rx_par_q) != PAR_ODD);
  assign rx_good    = rx_done && rx_s2_q && !rx_bad_par;
  assign rx_pop     = sensor_valid && sensor_ready;
  assign rx_push    = rx_good && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx_sig;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      ferr_q     <= rx_done && !rx_s2_q;
      perr_q     <= rx_done && rx_s2_q && rx_bad_par;
      ovr_q      <= rx_good && rx_full && !rx_pop;
    end
  end

  assign sensor_valid = !rx_empty;
  assign sensor_data  = sensor_valid ? rx_head : '0;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// Testbench for uart_core: an even-parity instance driven directly and an
// odd-parity instance with its TX looped back to its RX.
module tb_uart_core;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       e_rx = 1'b1, e_tx, e_valid = 1'b0, e_rdy, e_vout, e_sready = 1'b0;
  logic       e_perr, e_ferr, e_ovr;
  logic [7:0] e_din = '0, e_dout;
  logic       o_tx, o_valid = 1'b0, o_rdy, o_vout, o_sready = 1'b0;
  logic       o_perr, o_ferr, o_ovr;
  logic [7:0] o_din = '0, o_dout;

  uart_core #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
              .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .rstn(rstn), .rx_sig(e_rx), .tx_sig(e_tx),
    .data_from_sensor(e_din), .valid_from_sensor(e_valid), .ready_to_sensor(e_rdy),
    .sensor_data(e_dout), .sensor_valid(e_vout), .sensor_ready(e_sready),
    .parity_err(e_perr), .frame_err(e_ferr), .overrun(e_ovr)
  );

  uart_core #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
              .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .rstn(rstn), .rx_sig(o_tx), .tx_sig(o_tx),
    .data_from_sensor(o_din), .valid_from_sensor(o_valid), .ready_to_sensor(o_rdy),
    .sensor_data(o_dout), .sensor_valid(o_vout), .sensor_ready(o_sready),
    .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr)
  );

  int e_perr_n = 0, e_ferr_n = 0, e_ovr_n = 0, o_err_n = 0;
  always @(negedge clk) begin
    if (e_perr) e_perr_n++;
    if (e_ferr) e_ferr_n++;
    if (e_ovr)  e_ovr_n++;
    if (o_perr || o_ferr || o_ovr) o_err_n++;
  end

  logic exp_line[$];
  logic act_line[$];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    e_perr_n = 0; e_ferr_n = 0; e_ovr_n = 0; o_err_n = 0;
  endtask

  // Line-level picture of one frame: start, LSB-first data, optional parity, stop.
  function automatic void add_frame(input logic [7:0] d, input int mode);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (mode == 1) b.push_back(($countones(d) % 2) == 0);
    if (mode == 2) b.push_back(($countones(d) % 2) == 1);
    b.push_back(1'b1);
    foreach (b[i]) repeat (CPB) exp_line.push_back(b[i]);
  endfunction

  function automatic void add_idle(input int n);
    repeat (n) exp_line.push_back(1'b1);
  endfunction

  task automatic capture(input bit odd, input int n);
    act_line.delete();
    repeat (n) begin
      act_line.push_back(odd ? o_tx : e_tx);
      tick();
    end
  endtask

  task automatic push_e(input logic [7:0] d);
    e_din = d; e_valid = 1'b1;
    tick();
    e_valid = 1'b0;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic send_e(input logic [7:0] d, input logic pbit, input logic sbit);
    e_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      e_rx = d[i]; tick(CPB);
    end
    e_rx = pbit; tick(CPB);
    e_rx = sbit; tick(CPB);
    e_rx = 1'b1; tick(6);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    n_tests++;
    if ({e_tx, e_rdy, e_vout, e_dout, e_perr, e_ferr, e_ovr} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_even: got tx=%b rdy=%b v=%b d=%h pe=%b fe=%b ov=%b want 1 0 0 00 0 0 0",
               e_tx, e_rdy, e_vout, e_dout, e_perr, e_ferr, e_ovr);
    end
    n_tests++;
    if ({o_tx, o_rdy, o_vout, o_dout} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_odd: got tx=%b rdy=%b v=%b d=%h want 1 0 0 00", o_tx, o_rdy, o_vout, o_dout);
    end
    rstn = 1'b1;
    tick();
    n_tests++;
    if ({e_rdy, o_rdy} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b%b want 11", e_rdy, o_rdy);
    end
    tick(2);
  endtask

  task automatic test_tx_frame(input logic [7:0] d);
    int bad = 0, first = -1;
    exp_line.delete();
    push_e(d);
    add_idle(1);
    add_frame(d, 2);
    add_idle(10);
    capture(1'b0, exp_line.size());
    foreach (exp_line[i]) if (act_line[i] !== exp_line[i]) begin
      bad++;
      if (first < 0) first = i;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL tx_frame_%h: %0d cycles differ, first at cycle %0d got %b want %b",
               d, bad, first, act_line[first], exp_line[first]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[3];
    int bad = 0, first = -1;
    exp_line.delete();
    add_idle(1);
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'($urandom_range(0, 255));
      add_frame(d[i], 2);
    end
    add_idle(10);
    e_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_din = d[i];
      n_tests++;
      if (e_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_%0d: got %b want 1", i, e_rdy);
      end
      tick();
    end
    e_valid = 1'b0;
    void'(exp_line.pop_front());
    void'(exp_line.pop_front());
    capture(1'b0, exp_line.size());
    foreach (exp_line[i]) if (act_line[i] !== exp_line[i]) begin
      bad++;
      if (first < 0) first = i;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_line: %0d cycles differ, first at cycle %0d got %b want %b",
               bad, first, act_line[first], exp_line[first]);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    logic [7:0] d, want;
    int bad = 0, first = -1, waited;
    clear_counts();
    exp_line.delete();
    o_din = 8'h3C; o_valid = 1'b1;
    tick();
    o_valid = 1'b0;
    add_idle(1);
    add_frame(8'h3C, 1);
    add_idle(10);
    capture(1'b1, exp_line.size());
    foreach (exp_line[i]) if (act_line[i] !== exp_line[i]) begin
      bad++;
      if (first < 0) first = i;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL loop_line_3c: %0d cycles differ, first at cycle %0d got %b want %b",
               bad, first, act_line[first], exp_line[first]);
    end
    n_tests++;
    if (act_line[1 + 9 * CPB + 5] !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_parity_bit: got %b want 1", act_line[1 + 9 * CPB + 5]);
    end
    n_tests++;
    if ({o_vout, o_dout} !== {1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL loop_rx_3c: got v=%b d=%h want v=1 d=3c", o_vout, o_dout);
    end
    o_sready = 1'b1; tick(); o_sready = 1'b0;
    n_tests++;
    if (o_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_pop_empty: got v=%b want 0", o_vout);
    end
    o_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      q.push_back(d);
      o_din = d;
      tick();
    end
    o_valid = 1'b0;
    tick(4 * 11 * CPB + 20);
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (o_vout !== 1'b1 && waited < 200) begin
        tick();
        waited++;
      end
      want = q.pop_front();
      n_tests++;
      if (o_vout !== 1'b1 || o_dout !== want) begin
        n_fail++;
        $display("FAIL loop_rand_%0d: got v=%b d=%h want v=1 d=%h", i, o_vout, o_dout, want);
      end
      o_sready = 1'b1; tick(); o_sready = 1'b0;
    end
    n_tests++;
    if (o_err_n != 0 || o_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_clean: got errs=%0d v=%b want 0 0", o_err_n, o_vout);
    end
  endtask

  task automatic test_rx_good();
    logic [7:0] d;
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send_e(d, even_par(d), 1'b1);
      n_tests++;
      if ({e_vout, e_dout} !== {1'b1, d}) begin
        n_fail++;
        $display("FAIL rx_good_%0d: got v=%b d=%h want v=1 d=%h", i, e_vout, e_dout, d);
      end
      e_sready = 1'b1; tick(); e_sready = 1'b0;
    end
    n_tests++;
    if (e_perr_n + e_ferr_n + e_ovr_n != 0 || e_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_good_clean: got pe=%0d fe=%0d ov=%0d v=%b want 0 0 0 0",
               e_perr_n, e_ferr_n, e_ovr_n, e_vout);
    end
  endtask

  task automatic test_rx_errors();
    clear_counts();
    send_e(8'h3C, 1'b1, 1'b1);
    n_tests++;
    if (e_perr_n != 1 || e_ferr_n != 0 || e_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_parity_err: got pe=%0d fe=%0d v=%b want 1 0 0", e_perr_n, e_ferr_n, e_vout);
    end
    clear_counts();
    send_e(8'h3C, 1'b0, 1'b0);
    n_tests++;
    if (e_perr_n != 0 || e_ferr_n != 1 || e_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_frame_err: got pe=%0d fe=%0d v=%b want 0 1 0", e_perr_n, e_ferr_n, e_vout);
    end
    clear_counts();
    send_e(8'h3C, 1'b1, 1'b0);
    n_tests++;
    if (e_perr_n != 0 || e_ferr_n != 1 || e_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_err_precedence: got pe=%0d fe=%0d v=%b want 0 1 0", e_perr_n, e_ferr_n, e_vout);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    clear_counts();
    e_sready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      send_e(d, even_par(d), 1'b1);
    end
    n_tests++;
    if (e_ovr_n != 0) begin
      n_fail++;
      $display("FAIL ovr_early: got %0d pulses want 0", e_ovr_n);
    end
    send_e(8'h05, even_par(8'h05), 1'b1);
    n_tests++;
    if (e_ovr_n != 1) begin
      n_fail++;
      $display("FAIL ovr_fifth: got %0d pulses want 1", e_ovr_n);
    end
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if ({e_vout, e_dout} !== {1'b1, 8'(i)}) begin
        n_fail++;
        $display("FAIL ovr_read_%0d: got v=%b d=%h want v=1 d=%h", i, e_vout, e_dout, 8'(i));
      end
      e_sready = 1'b1; tick(); e_sready = 1'b0;
    end
    n_tests++;
    if (e_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drained: got v=%b want 0", e_vout);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    e_rx = 1'b0; tick(3);
    e_rx = 1'b1; tick(40);
    n_tests++;
    if (e_perr_n + e_ferr_n + e_ovr_n != 0 || e_vout !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_glitch: got pe=%0d fe=%0d ov=%0d v=%b want 0 0 0 0",
               e_perr_n, e_ferr_n, e_ovr_n, e_vout);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    int bad = 0;
    d = 8'($urandom_range(0, 255));
    push_e(d);
    tick(1 + 4 * CPB + 4);
    n_tests++;
    if (e_tx !== d[3]) begin
      n_fail++;
      $display("FAIL midtx_bit3: got %b want %b", e_tx, d[3]);
    end
    rstn = 1'b0;
    tick();
    n_tests++;
    if (e_tx !== 1'b1 || e_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL midtx_reset: got tx=%b rdy=%b want 1 0", e_tx, e_rdy);
    end
    rstn = 1'b1;
    tick();
    n_tests++;
    if (e_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midtx_ready: got %b want 1", e_rdy);
    end
    capture(1'b0, 150);
    foreach (act_line[i]) if (act_line[i] !== 1'b1) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midtx_no_residual: got %0d low cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'hA5);
    test_tx_frame(8'($urandom_range(0, 255)));
    test_back_to_back();
    test_loopback();
    test_rx_good();
    test_rx_errors();
    test_overrun();
    test_glitch();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
`default_nettype wire
